click_cmd_sequencer: RTL and testbench

//  Board-level test sequencer: turns push-button single/double clicks into SDRAM controller

---
 rtl/click_cmd_pkg.sv | 31 +++
 rtl/click_classifier.sv | 94 +++++++++
 rtl/click_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_click_cmd_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/click_cmd_pkg.sv
// Shared types for the click-to-SDRAM-command test sequencer.
package click_cmd_pkg;

  localparam logic [15:0] DEFAULT_SEED = 16'hA5C3;

  typedef enum logic {
    K_IDLE,
    K_WAIT
  } cls_state_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WR,
    C_RD,
    C_RD_WAIT
  } cmd_state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_SINGLE,
    EV_DOUBLE
  } ev_e;

  // Click count at window close -> event kind.
  function automatic ev_e click_event(input logic [1:0] clicks);
    if (clicks >= 2'd2) return EV_DOUBLE;
    if (clicks == 2'd1) return EV_SINGLE;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/click_classifier.sv
// Button front end: 2-FF synchroniser, debounce and click-window classifier.
// Emits one-cycle single/double click events at the close of each window.
module click_classifier
  import click_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 65536,
  parameter int unsigned WINDOW_CYC   = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_button,
  output logic o_ev_single,
  output logic o_ev_double
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int unsigned WIN_W = $clog2(WINDOW_CYC);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_press;
  logic [DB_W-1:0]  r_db_cnt;
  cls_state_e       r_state;
  logic [WIN_W-1:0] r_win_cnt;
  logic [1:0]       r_clicks;
  logic [1:0]       w_clicks_nxt;
  ev_e              w_ev_close;

  // A press in the closing cycle still counts toward the event.
  assign w_clicks_nxt = (r_press && (r_clicks != 2'd2)) ? r_clicks + 2'd1 : r_clicks;
  assign w_ev_close   = click_event(w_clicks_nxt);

  // Synchronise and debounce; press pulses on the debounced rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_deb    <= 1'b0;
      r_press  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_deb) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
          r_deb    <= r_sync2;
          r_db_cnt <= '0;
          r_press  <= r_sync2;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Window counter opened by the first press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= K_IDLE;
      r_win_cnt   <= '0;
      r_clicks    <= 2'd0;
      o_ev_single <= 1'b0;
      o_ev_double <= 1'b0;
    end else begin
      o_ev_single <= 1'b0;
      o_ev_double <= 1'b0;
      case (r_state)
        K_IDLE: begin
          if (r_press) begin
            r_state   <= K_WAIT;
            r_win_cnt <= '0;
            r_clicks  <= 2'd1;
          end
        end
        K_WAIT: begin
          r_clicks <= w_clicks_nxt;
          if (r_win_cnt == WIN_W'(WINDOW_CYC - 1)) begin
            o_ev_single <= (w_ev_close == EV_SINGLE);
            o_ev_double <= (w_ev_close == EV_DOUBLE);
            r_state     <= K_IDLE;
          end else begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
          end
        end
        default: r_state <= K_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/click_cmd_sequencer.sv
// Button clicks -> SDRAM host commands: single = pattern write, double = read-back.
// Optional CLICK_CMD_COMPARE_EN adds match/mismatch read-back compare outputs.
module click_cmd_sequencer
  import click_cmd_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 24,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       DEBOUNCE_CYC = 65536,
  parameter int unsigned       WINDOW_CYC   = 1048576,
  parameter int unsigned       RD_TIMEOUT   = 1024,
  parameter logic [DATA_W-1:0] PATTERN_SEED = DATA_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button,
  output logic              cmd_valid,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ready,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] last_data,
  output logic              busy,
  output logic              err,
  output logic              dropped
`ifdef CLICK_CMD_COMPARE_EN
  ,
  output logic              match,
  output logic              mismatch
`endif
);

  localparam int unsigned TO_W = $clog2(RD_TIMEOUT);

  logic              w_ev_single;
  logic              w_ev_double;
  ev_e               w_ev;
  cmd_state_e        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_cmd_valid;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic [DATA_W-1:0] r_last_data;
  logic              r_busy;
  logic              r_err;
  logic              r_dropped;
`ifdef CLICK_CMD_COMPARE_EN
  logic              r_match;
  logic              r_mismatch;
`endif

  click_classifier #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .WINDOW_CYC  (WINDOW_CYC)
  ) u_classifier (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_button   (button),
    .o_ev_single(w_ev_single),
    .o_ev_double(w_ev_double)
  );

  assign w_ev = w_ev_double ? EV_DOUBLE : (w_ev_single ? EV_SINGLE : EV_NONE);

  // Command FSM; the read address stays in r_cmd_addr for the compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= C_IDLE;
      r_wr_ptr    <= '0;
      r_to_cnt    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_last_data <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_dropped   <= 1'b0;
`ifdef CLICK_CMD_COMPARE_EN
      r_match     <= 1'b0;
      r_mismatch  <= 1'b0;
`endif
    end else begin
      if ((r_state != C_IDLE) && (w_ev != EV_NONE)) r_dropped <= 1'b1;
      case (r_state)
        C_IDLE: begin
          if (w_ev == EV_SINGLE) begin
            r_state     <= C_WR;
            r_cmd_valid <= 1'b1;
            r_cmd_we    <= 1'b1;
            r_cmd_addr  <= r_wr_ptr;
            r_cmd_wdata <= DATA_W'(r_wr_ptr) ^ PATTERN_SEED;
            r_busy      <= 1'b1;
          end else if (w_ev == EV_DOUBLE) begin
            r_state     <= C_RD;
            r_cmd_valid <= 1'b1;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= r_wr_ptr - ADDR_W'(1);
            r_busy      <= 1'b1;
`ifdef CLICK_CMD_COMPARE_EN
            r_match     <= 1'b0;
            r_mismatch  <= 1'b0;
`endif
          end
        end
        C_WR: begin
          if (cmd_ready) begin
            r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
            r_cmd_valid <= 1'b0;
            r_state     <= C_IDLE;
            r_busy      <= 1'b0;
          end
        end
        C_RD: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_to_cnt    <= '0;
            r_state     <= C_RD_WAIT;
          end
        end
        C_RD_WAIT: begin
          if (rd_valid) begin
            r_last_data <= rd_data;
            r_state     <= C_IDLE;
            r_busy      <= 1'b0;
`ifdef CLICK_CMD_COMPARE_EN
            r_match     <= (rd_data == (DATA_W'(r_cmd_addr) ^ PATTERN_SEED));
            r_mismatch  <= (rd_data != (DATA_W'(r_cmd_addr) ^ PATTERN_SEED));
`endif
          end else if (r_to_cnt == TO_W'(RD_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= C_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: begin
          r_state <= C_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_we    = r_cmd_we;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_wdata = r_cmd_wdata;
  assign last_data = r_last_data;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dropped   = r_dropped;
`ifdef CLICK_CMD_COMPARE_EN
  assign match     = r_match;
  assign mismatch  = r_mismatch;
`endif

endmodule

// File: tb/tb_click_cmd_sequencer.sv
// Randomised self-checking bench for click_cmd_sequencer against a transaction-level model.
module tb_click_cmd_sequencer;

  localparam logic [15:0] SEED = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        button = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = 16'h0;
  logic        cmd_valid, cmd_we, busy, err, dropped;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata, last_data;
`ifdef CLICK_CMD_COMPARE_EN
  logic        match, mismatch;
`endif

  click_cmd_sequencer #(
    .ADDR_W(8), .DATA_W(16), .DEBOUNCE_CYC(4), .WINDOW_CYC(64), .RD_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .last_data(last_data), .busy(busy), .err(err), .dropped(dropped)
`ifdef CLICK_CMD_COMPARE_EN
    , .match(match), .mismatch(mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: write pointer, sticky flags, memory image, last read word.
  int          n_checks = 0;
  int          n_errs = 0;
  int          exp_wr_ptr = 0;
  bit          exp_err = 0;
  bit          exp_dropped = 0;
  bit          exp_match = 0;
  bit          exp_mismatch = 0;
  logic [15:0] exp_last = 16'h0;
  logic [15:0] mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int len);
    button = 1'b1;
    tick(len);
    button = 1'b0;
  endtask

  task automatic click_double(input int len1, input int gap, input int len2);
    press(len1);
    tick(gap - len1);
    press(len2);
  endtask

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk("cmd_wait", 32'(ok), 32'd1);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_dropped"}, 32'(dropped), 32'(exp_dropped));
    chk({tag, "_last"}, 32'(last_data), 32'(exp_last));
`ifdef CLICK_CMD_COMPARE_EN
    chk({tag, "_cmp"}, {match, mismatch}, {exp_match, exp_mismatch});
`endif
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (cmd_valid) seen++;
      tick(1);
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  task automatic reset_model();
    exp_wr_ptr = 0;
    exp_err = 0;
    exp_dropped = 0;
    exp_last = 16'h0;
    exp_match = 0;
    exp_mismatch = 0;
  endtask

  // Serve one command. rd_dly < 0 means no read response.
  task automatic serve(input bit exp_we, input int rdy_dly, input int rd_dly,
                       input bit corrupt, input bit click_in_hold);
    bit          ok;
    logic [7:0]  a;
    logic [15:0] d, rv;
    wait_cmd(ok);
    if (!ok) return;
    a = exp_we ? 8'(exp_wr_ptr) : 8'(exp_wr_ptr - 1);
    d = 16'(a) ^ SEED;
    chk("cmd_we", 32'(cmd_we), 32'(exp_we));
    chk("cmd_addr", 32'(cmd_addr), 32'(a));
    if (exp_we) chk("cmd_wdata", 32'(cmd_wdata), 32'(d));
    chk("busy_on", 32'(busy), 32'd1);
    for (int i = 0; i < rdy_dly; i++) begin
      if (click_in_hold && i == 0) button = 1'b1;
      if (click_in_hold && i == 10) button = 1'b0;
      tick(1);
      chk("hold_cmd", {cmd_valid, cmd_we, cmd_addr}, {1'b1, exp_we, a});
      if (exp_we) chk("hold_wdata", 32'(cmd_wdata), 32'(d));
    end
    if (click_in_hold) begin
      exp_dropped = 1;
      chk("hold_dropped", 32'(dropped), 32'd1);
    end
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    chk("accept_drop", 32'(cmd_valid), 32'd0);
    if (exp_we) begin
      mem[a] = d;
      exp_wr_ptr = (exp_wr_ptr + 1) % 256;
      chk("wr_busy_off", 32'(busy), 32'd0);
    end else if (rd_dly >= 0) begin
      rv = corrupt ? (mem[a] ^ (16'h1 << $urandom_range(15, 0))) : mem[a];
      tick(rd_dly);
      chk("rd_busy_wait", 32'(busy), 32'd1);
      rd_valid = 1'b1;
      rd_data  = rv;
      tick(1);
      rd_valid = 1'b0;
      rd_data  = 16'($urandom);
      exp_last     = rv;
      exp_match    = (rv == (16'(a) ^ SEED));
      exp_mismatch = !exp_match;
      chk("rd_busy_off", 32'(busy), 32'd0);
    end else begin
      tick(15);
      chk("to_err_early", 32'(err), 32'(exp_err));
      chk("to_busy", 32'(busy), 32'd1);
      tick(1);
      exp_err = 1;
      chk("to_busy_off", 32'(busy), 32'd0);
    end
    chk_status("post");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int kind;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    tick(3);
    chk("rst_ctrl", {cmd_valid, cmd_we, busy, err, dropped}, 32'd0);
    chk("rst_addr", 32'(cmd_addr), 32'd0);
    chk("rst_wdata", 32'(cmd_wdata), 32'd0);
    chk_status("rst");
    rst_n = 1'b1;
    tick(2);

    // Single click -> write of seed at address 0.
    press(10);
    serve(1, 0, 0, 0, 0);
    chk("t1_ptr", 32'(exp_wr_ptr), 32'd1);

    // Double click -> read back address 0.
    click_double(10, 20, 10);
    serve(0, 0, 3, 0, 0);
    chk("t2_last", 32'(last_data), 32'hA5C3);
`ifdef CLICK_CMD_COMPARE_EN
    chk("t2_match", 32'(match), 32'd1);
`endif

    // Short glitches are filtered.
    button = 1'b1; tick(2); button = 1'b0;
    quiet("glitch2", 150);
    button = 1'b1; tick(3); button = 1'b0;
    quiet("glitch3", 150);

    // Second press in the closing window cycle counts; one cycle later it starts a new window.
    click_double(10, 64, 10);
    serve(0, 1, 15, 0, 0);
    click_double(10, 65, 10);
    serve(1, 0, 0, 0, 0);
    serve(1, 0, 0, 0, 0);

    // Held command while a click arrives -> dropped, no extra command.
    press(10);
    serve(1, 100, 0, 0, 1);
    quiet("no_extra", 100);

    // Read timeout, then the next click is served.
    click_double(8, 24, 8);
    serve(0, 0, -1, 0, 0);
    press(10);
    serve(1, 2, 0, 0, 0);

    // Random mix of clicks and controller behaviour.
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(9, 0));
      if (kind <= 5) begin
        press(int'($urandom_range(12, 4)));
        serve(1, int'($urandom_range(4, 0)), 0, 0, 0);
      end else begin
        click_double(int'($urandom_range(10, 4)), int'($urandom_range(40, 16)),
                     int'($urandom_range(10, 4)));
        serve(0, int'($urandom_range(4, 0)),
              (kind == 9) ? -1 : int'($urandom_range(15, 0)),
              ($urandom_range(3, 0) == 0), 0);
      end
    end

    // 256 writes force the pointer through 0xFF -> 0x00.
    for (int n = 0; n < 256; n++) begin
      press(int'($urandom_range(12, 4)));
      serve(1, int'($urandom_range(3, 0)), 0, 0, 0);
    end

    // Reset while a write is pending.
    press(10);
    wait_cmd(ok);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    reset_model();
    chk("mrst_ctrl", {cmd_valid, cmd_we, busy, err, dropped}, 32'd0);
    chk("mrst_addr", 32'(cmd_addr), 32'd0);
    chk_status("mrst");

    // Reset during an outstanding read; the late response is ignored.
    click_double(8, 20, 8);
    wait_cmd(ok);
    chk("mrst_rd_addr", 32'(cmd_addr), 32'hFF);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    rd_valid = 1'b1;
    rd_data  = 16'h1234;
    tick(1);
    rd_valid = 1'b0;
    chk("late_rd_last", 32'(last_data), 32'd0);
    chk("late_rd_busy", 32'(busy), 32'd0);
    press(10);
    serve(1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
